// File: rtl/ysyx_22040632_div32.sv
// 32-bit radix-2 restoring divider for the RV64 W-type div/rem ops.
// One quotient bit per cycle; the 32-bit result is sign-extended to 64 bits.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | in_ready=1, waiting for an operation
// CALC  | shift-subtract step each cycle, cnt runs 0..31
// DONE  | out_valid=1, result held until out_ready
module ysyx_22040632_div32 (
   input  logic        clk,
   input  logic        rrst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  op,
   input  logic [63:0] src1,
   input  logic [63:0] src2,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [4:0]  cnt;
   logic [1:0]  op_r;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] dvs;
   logic        neg_q;
   logic        neg_r;
   logic [63:0] result_r;

   logic [31:0] a;
   logic [31:0] b;
   logic        signed_op;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] rem_sh;
   logic [32:0] diff;
   logic        take;
   logic [31:0] rem_step;
   logic [31:0] quo_step;
   logic [31:0] q_fin;
   logic [31:0] r_fin;
   logic [31:0] sel;
   logic        unused_hi;

   assign a         = src1[31:0];
   assign b         = src2[31:0];
   assign unused_hi = ^{src1[63:32], src2[63:32]};
   assign signed_op = ~op[0];
   assign a_mag     = (signed_op && a[31]) ? (32'd0 - a) : a;
   assign b_mag     = (signed_op && b[31]) ? (32'd0 - b) : b;

   // Remainder stays below the divisor, so 32 bits plus one shift-in bit suffice.
   assign rem_sh   = {rem, quo[31]};
   assign diff     = rem_sh - {1'b0, dvs};
   assign take     = ~diff[32];
   assign rem_step = take ? diff[31:0] : rem_sh[31:0];
   assign quo_step = {quo[30:0], take};
   assign q_fin    = neg_q ? (32'd0 - quo_step) : quo_step;
   assign r_fin    = neg_r ? (32'd0 - rem_step) : rem_step;
   assign sel      = op_r[1] ? r_fin : q_fin;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign result    = result_r;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (in_valid) state_nxt = (b == 32'd0) ? S_DONE : S_CALC;
         S_CALC: if (cnt == 5'd31) state_nxt = S_DONE;
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk or negedge rrst_n) begin
      if (!rrst_n) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rrst_n) begin
      if (!rrst_n) begin
         cnt      <= 5'd0;
         op_r     <= 2'd0;
         quo      <= 32'd0;
         rem      <= 32'd0;
         dvs      <= 32'd0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_r <= 64'd0;
      end else if (flush) begin
         cnt <= 5'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_r  <= op;
                  cnt   <= 5'd0;
                  quo   <= a_mag;
                  rem   <= 32'd0;
                  dvs   <= b_mag;
                  neg_q <= signed_op & (a[31] ^ b[31]);
                  neg_r <= signed_op & a[31];
                  if (b == 32'd0)
                     result_r <= op[1] ? {{32{a[31]}}, a} : {64{1'b1}};
               end
            end
            S_CALC: begin
               rem <= rem_step;
               quo <= quo_step;
               cnt <= cnt + 5'd1;
               if (cnt == 5'd31) result_r <= {{32{sel[31]}}, sel};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22040632_div32.sv
// Self-checking bench for ysyx_22040632_div32: directed vector table,
// flush/hold/reset corner sequences and random ops against an arithmetic model.
module tb_ysyx_22040632_div32;

   logic        clk;
   logic        rrst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic [63:0] src1;
   logic [63:0] src2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;

   int checks = 0;
   int errors = 0;

   ysyx_22040632_div32 dut (
      .clk       (clk),
      .rrst_n    (rrst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [63:0] s1;
      logic [63:0] s2;
      logic [63:0] exp_res;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Plain-arithmetic reference: RISC-V W-type division semantics.
   function automatic logic [63:0] ref_div(input logic [1:0] o, input logic [63:0] s1,
                                           input logic [63:0] s2);
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r32;
      longint      sa;
      longint      sb;
      a  = s1[31:0];
      b  = s2[31:0];
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (b == 32'd0)      r32 = o[1] ? a : 32'hFFFF_FFFF;
      else if (!o[0])      r32 = o[1] ? 32'(sa % sb) : 32'(sa / sb);
      else                 r32 = o[1] ? (a % b) : (a / b);
      return {{32{r32[31]}}, r32};
   endfunction

   // Issue one op, scramble inputs after accept, wait for out_valid, handshake.
   task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
      @(negedge clk);
      in_valid = 1'b1;
      op       = o;
      src1     = a;
      src2     = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op       = 2'($urandom);
      src1     = {$urandom, $urandom};
      src2     = {$urandom, $urandom};
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = result;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   vec_t        vecs[$];
   logic [63:0] res;
   logic [63:0] held;
   int          lat;
   int          seen;

   initial begin
      rrst_n    = 1'b0;
      in_valid  = 1'b0;
      op        = 2'd0;
      src1      = 64'd0;
      src2      = 64'd0;
      flush     = 1'b0;
      out_ready = 1'b0;

      vecs.push_back('{2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33});
      vecs.push_back('{2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33});
      vecs.push_back('{2'b01, 64'h1234_5678_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33});
      vecs.push_back('{2'b00, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
      vecs.push_back('{2'b11, 64'd5, 64'd0, 64'h0000_0000_0000_0005, 1});
      vecs.push_back('{2'b00, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 33});
      vecs.push_back('{2'b10, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 33});
      vecs.push_back('{2'b01, 64'd100, 64'd7, 64'd14, 33});
      vecs.push_back('{2'b11, 64'hFFFF_FFFF, 64'h10, 64'hF, 33});
      vecs.push_back('{2'b10, 64'h0000_0000_FFFF_FFF9, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF9, 1});
      vecs.push_back('{2'b00, 64'd7, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 33});
      vecs.push_back('{2'b10, 64'd7, 64'hFFFF_FFFE, 64'd1, 33});

      #12;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_result", result, 64'd0);
      @(negedge clk);
      rrst_n = 1'b1;
      #1;
      check("post_reset_in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].s1, vecs[i].s2, res, lat);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("vec%0d_idle_after", i), 64'(in_ready), 64'd1);
      end

      // Flush while the counter is 10: op is dropped, divider idle next cycle.
      @(negedge clk);
      in_valid = 1'b1; op = 2'b00; src1 = 64'd1000; src2 = 64'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("flush_no_valid", 64'(seen), 64'd0);
      run_op(2'b01, 64'd100, 64'd7, res, lat);
      check("after_flush_result", res, 64'd14);
      check("after_flush_latency", 64'(lat), 64'd33);

      // Hold in DONE with out_ready low while a new op is offered.
      @(negedge clk);
      in_valid = 1'b1; op = 2'b00; src1 = 64'hFFFF_FFFF_FFFF_FF9C; src2 = 64'd9;
      @(posedge clk); #1;
      src1 = 64'd77; src2 = 64'd5; op = 2'b01;
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("hold_latency", 64'(lat), 64'd33);
      held = result;
      check("hold_result", held, ref_div(2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9));
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d_result", k), result, held);
         check($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'd0);
         check($sformatf("hold%0d_out_valid", k), 64'(out_valid), 64'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("handshake_no_accept", 64'(in_ready), 64'd1);
      check("handshake_out_valid", 64'(out_valid), 64'd0);

      // Asynchronous reset while in DONE.
      @(negedge clk);
      in_valid = 1'b1; op = 2'b11; src1 = 64'd9; src2 = 64'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("pre_reset_out_valid", 64'(out_valid), 64'd1);
      @(negedge clk);
      rrst_n = 1'b0;
      #1;
      check("async_reset_out_valid", 64'(out_valid), 64'd0);
      check("async_reset_result", result, 64'd0);
      @(negedge clk);
      rrst_n = 1'b1;
      #1;
      check("after_reset_in_ready", 64'(in_ready), 64'd1);
      seen = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      check("after_reset_no_valid", 64'(seen), 64'd0);

      // Random ops against the arithmetic model.
      for (int n = 0; n < 40; n++) begin
         logic [1:0]  ro;
         logic [63:0] ra;
         logic [63:0] rb;
         ro = 2'($urandom_range(0, 3));
         ra = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0:       rb = {$urandom, 32'd0};
            1, 2:    rb = {$urandom, 32'($urandom_range(1, 20))};
            3:       rb = {$urandom, 32'hFFFF_FFFF - 32'($urandom_range(0, 5))};
            default: rb = {$urandom, $urandom};
         endcase
         run_op(ro, ra, rb, res, lat);
         check($sformatf("rand%0d_result", n), res, ref_div(ro, ra, rb));
         check($sformatf("rand%0d_latency", n), 64'(lat), (rb[31:0] == 32'd0) ? 64'd1 : 64'd33);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
